// File: rtl/keyboard_matrix_pkg.sv
`default_nettype none
// ============================================================================
// keyboard_matrix_pkg : address map, PIA register selects and window helper
// Revision 2.0
// ============================================================================
package keyboard_matrix_pkg;

    localparam int KBD_ROW_COUNT  = 10;
    localparam int KBD_ADDR_WIDTH = 5;
    localparam int KBD_HOLD_BASE  = KBD_ROW_COUNT;
    localparam int KBD_SCAN_ADDR  = 2 * KBD_ROW_COUNT;

    localparam int                      PIA_RS_WIDTH = 2;
    localparam logic [PIA_RS_WIDTH-1:0] PIA_PORTA    = 2'd0;
    localparam logic [PIA_RS_WIDTH-1:0] PIA_PORTB    = 2'd2;

    // True when the word address falls on a row, hold or the scan counter.
    function automatic logic wb_kbd_addr(input logic [KBD_ADDR_WIDTH-1:0] addr,
                                         input int row_count);
        return int'(addr) <= 2 * row_count;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keyboard_row_hold.sv
`default_nettype none
// ============================================================================
// keyboard_row_hold : per-row auto-release down-counter with expire pulse
// Revision 2.0
// ============================================================================
module keyboard_row_hold #(
    parameter int HOLD_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [HOLD_WIDTH-1:0] load_value,
    input  logic                  dec,
    output logic [HOLD_WIDTH-1:0] count,
    output logic                  expire
);

    logic [HOLD_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Combinational so the row releases on the same edge as the 1 -> 0 step.
    assign expire = dec & ~load & (r_count == HOLD_WIDTH'(1));
    assign count  = r_count;

endmodule
`default_nettype wire

// File: rtl/keyboard_matrix.sv
`default_nettype none
// ============================================================================
// keyboard_matrix : Wishbone-written key matrix scanned by the 6502 via PIA1
// Revision 2.0
// ============================================================================
module keyboard_matrix
    import keyboard_matrix_pkg::*;
#(
    parameter int ROW_COUNT     = KBD_ROW_COUNT,
    parameter int COL_WIDTH     = 8,
    parameter int ROW_SEL_WIDTH = 4,
    parameter int HOLD_WIDTH    = 4
) (
    input  logic                      wb_clock_i,
    input  logic                      wb_reset_i,
    input  logic [KBD_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [COL_WIDTH-1:0]      wb_data_i,
    output logic [COL_WIDTH-1:0]      wb_data_o,
    input  logic                      wb_we_i,
    input  logic                      wb_cycle_i,
    input  logic                      wb_strobe_i,
    input  logic                      wb_sel_i,
    output logic                      wb_stall_o,
    output logic                      wb_ack_o,
    input  logic [COL_WIDTH-1:0]      cpu_data_i,
    output logic [COL_WIDTH-1:0]      cpu_data_o,
    output logic                      cpu_data_oe,
    input  logic                      cpu_we_i,
    input  logic                      cpu_strobe_i,
    input  logic                      pia1_cs_i,
    input  logic [PIA_RS_WIDTH-1:0]   pia1_rs_i
);

    logic [COL_WIDTH-1:0]     r_rows [ROW_COUNT];
    logic [ROW_SEL_WIDTH-1:0] r_row_sel;
    logic [7:0]               r_scan;
    logic                     r_ack;
    logic [COL_WIDTH-1:0]     r_rd_data;

    logic [HOLD_WIDTH-1:0]    w_hold [ROW_COUNT];
    logic [ROW_COUNT-1:0]     w_row_wr;
    logic [ROW_COUNT-1:0]     w_hold_wr;
    logic [ROW_COUNT-1:0]     w_dec;
    logic [ROW_COUNT-1:0]     w_expire;
    logic [COL_WIDTH-1:0]     w_rd_data;
    logic [COL_WIDTH-1:0]     w_port_b;

    logic w_req, w_wr, w_rd, w_scan_wr, w_read_event, w_porta_wr;
    logic w_unused_cpu;

    assign w_req        = wb_cycle_i & wb_strobe_i;
    assign w_wr         = w_req & wb_sel_i & wb_we_i;
    assign w_rd         = w_req & wb_sel_i & ~wb_we_i;
    assign w_scan_wr    = w_wr && (int'(wb_addr_i) == KBD_SCAN_ADDR);
    assign cpu_data_oe  = pia1_cs_i & ~cpu_we_i & (pia1_rs_i == PIA_PORTB);
    assign w_read_event = cpu_data_oe & cpu_strobe_i;
    assign w_porta_wr   = pia1_cs_i & cpu_strobe_i & cpu_we_i & (pia1_rs_i == PIA_PORTA);
    assign w_unused_cpu = ^cpu_data_i[COL_WIDTH-1:ROW_SEL_WIDTH];

    generate
        for (genvar g = 0; g < ROW_COUNT; g++) begin : g_row
            assign w_row_wr[g]  = w_wr && (int'(wb_addr_i) == g);
            assign w_hold_wr[g] = w_wr && (int'(wb_addr_i) == KBD_HOLD_BASE + g);
            // A Wishbone row write freezes the hold counter for that cycle too.
            assign w_dec[g]     = w_read_event && (int'(r_row_sel) == g) && !w_row_wr[g];

            keyboard_row_hold #(
                .HOLD_WIDTH (HOLD_WIDTH)
            ) u_hold (
                .clk        (wb_clock_i),
                .rst        (wb_reset_i),
                .load       (w_hold_wr[g]),
                .load_value (wb_data_i[HOLD_WIDTH-1:0]),
                .dec        (w_dec[g]),
                .count      (w_hold[g]),
                .expire     (w_expire[g])
            );
        end
    endgenerate

    always_comb begin
        w_rd_data = '1;
        w_port_b  = '1;
        for (int i = 0; i < ROW_COUNT; i++) begin
            if (int'(r_row_sel) == i) w_port_b = r_rows[i];
        end
        if (wb_kbd_addr(wb_addr_i, ROW_COUNT)) begin
            for (int i = 0; i < ROW_COUNT; i++) begin
                if (int'(wb_addr_i) == i)                 w_rd_data = r_rows[i];
                if (int'(wb_addr_i) == KBD_HOLD_BASE + i) w_rd_data = COL_WIDTH'(w_hold[i]);
            end
            if (int'(wb_addr_i) == KBD_SCAN_ADDR) w_rd_data = COL_WIDTH'(r_scan);
        end
    end

    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            r_ack     <= 1'b0;
            r_rd_data <= '1;
            r_row_sel <= '0;
            r_scan    <= '0;
            for (int i = 0; i < ROW_COUNT; i++) r_rows[i] <= '1;
        end else begin
            r_ack     <= w_req;
            r_rd_data <= w_rd ? w_rd_data : '1;
            if (w_porta_wr) r_row_sel <= cpu_data_i[ROW_SEL_WIDTH-1:0];
            if (w_scan_wr) begin
                r_scan <= '0;
            end else if (w_read_event && (r_row_sel == '0)) begin
                r_scan <= r_scan + 8'd1;
            end
            for (int i = 0; i < ROW_COUNT; i++) begin
                if (w_row_wr[i]) begin
                    r_rows[i] <= wb_data_i;
                end else if (w_expire[i]) begin
                    r_rows[i] <= '1;
                end
            end
        end
    end

    assign wb_ack_o   = r_ack;
    assign wb_data_o  = r_rd_data;
    assign wb_stall_o = 1'b0;
    assign cpu_data_o = w_port_b;

endmodule
`default_nettype wire

// File: tb/tb_keyboard_matrix.sv
`default_nettype none
// ============================================================================
// tb_keyboard_matrix : scoreboard bench for keyboard_matrix
// Revision 2.0
// ============================================================================
module tb_keyboard_matrix;
    import keyboard_matrix_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [KBD_ADDR_WIDTH-1:0] wb_addr_i;
    logic [7:0]                wb_data_i;
    logic [7:0]                wb_data_o;
    logic                      wb_we_i, wb_cycle_i, wb_strobe_i, wb_sel_i;
    logic                      wb_stall_o, wb_ack_o;
    logic [7:0]                cpu_data_i, cpu_data_o;
    logic                      cpu_data_oe, cpu_we_i, cpu_strobe_i, pia1_cs_i;
    logic [PIA_RS_WIDTH-1:0]   pia1_rs_i;

    always #5 clk = ~clk;

    keyboard_matrix dut (
        .wb_clock_i   (clk),
        .wb_reset_i   (rst),
        .wb_addr_i    (wb_addr_i),
        .wb_data_i    (wb_data_i),
        .wb_data_o    (wb_data_o),
        .wb_we_i      (wb_we_i),
        .wb_cycle_i   (wb_cycle_i),
        .wb_strobe_i  (wb_strobe_i),
        .wb_sel_i     (wb_sel_i),
        .wb_stall_o   (wb_stall_o),
        .wb_ack_o     (wb_ack_o),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .cpu_data_oe  (cpu_data_oe),
        .cpu_we_i     (cpu_we_i),
        .cpu_strobe_i (cpu_strobe_i),
        .pia1_cs_i    (pia1_cs_i),
        .pia1_rs_i    (pia1_rs_i)
    );

    typedef struct {
        logic       chk;
        logic [7:0] data;
        int         tag;
    } wb_exp_t;

    wb_exp_t    wb_q[$];
    logic [7:0] cpu_q[$];
    int         checks   = 0;
    int         failures = 0;

    always @(negedge clk) begin
        wb_exp_t    e;
        logic [7:0] ce;
        if (wb_ack_o === 1'b1) begin
            if (wb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL wb_ack_unexpected actual=ack required=no_ack t=%0t", $time);
            end else begin
                e = wb_q.pop_front();
                if (e.chk) begin
                    checks++;
                    if (wb_data_o !== e.data || wb_stall_o !== 1'b0) begin
                        failures++;
                        $display("FAIL wb_read tag=%0d actual=%h stall=%b required=%h stall=0",
                                 e.tag, wb_data_o, wb_stall_o, e.data);
                    end
                end
            end
        end
        if (cpu_data_oe === 1'b1 && cpu_strobe_i === 1'b1) begin
            checks++;
            if (cpu_q.size() == 0) begin
                failures++;
                $display("FAIL cpu_read_unexpected actual=%h required=none", cpu_data_o);
            end else begin
                ce = cpu_q.pop_front();
                if (cpu_data_o !== ce) begin
                    failures++;
                    $display("FAIL cpu_port_b actual=%h required=%h t=%0t", cpu_data_o, ce, $time);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wb_rd(input int a, input logic [7:0] exp);
        wb_exp_t e;
        e.chk = 1'b1; e.data = exp; e.tag = a;
        wb_q.push_back(e);
        wb_addr_i = KBD_ADDR_WIDTH'(a); wb_we_i = 1'b0; wb_sel_i = 1'b1;
        wb_cycle_i = 1'b1; wb_strobe_i = 1'b1;
        @(posedge clk); #1;
        wb_cycle_i = 1'b0; wb_strobe_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wb_wr(input int a, input logic [7:0] d, input logic sel);
        wb_exp_t e;
        e.chk = 1'b0; e.data = 8'h00; e.tag = a;
        wb_q.push_back(e);
        wb_addr_i = KBD_ADDR_WIDTH'(a); wb_data_i = d; wb_we_i = 1'b1; wb_sel_i = sel;
        wb_cycle_i = 1'b1; wb_strobe_i = 1'b1;
        @(posedge clk); #1;
        wb_cycle_i = 1'b0; wb_strobe_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic cpu_sel(input logic [7:0] v);
        pia1_cs_i = 1'b1; cpu_we_i = 1'b1; pia1_rs_i = PIA_PORTA;
        cpu_data_i = v; cpu_strobe_i = 1'b1;
        @(posedge clk); #1;
        pia1_cs_i = 1'b0; cpu_we_i = 1'b0; cpu_strobe_i = 1'b0;
    endtask

    task automatic cpu_rd(input logic [7:0] exp);
        cpu_q.push_back(exp);
        pia1_cs_i = 1'b1; cpu_we_i = 1'b0; pia1_rs_i = PIA_PORTB; cpu_strobe_i = 1'b1;
        @(posedge clk); #1;
        pia1_cs_i = 1'b0; cpu_strobe_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wb_addr_i = '0; wb_data_i = '0; wb_we_i = 1'b0; wb_cycle_i = 1'b0;
        wb_strobe_i = 1'b0; wb_sel_i = 1'b0;
        cpu_data_i = '0; cpu_we_i = 1'b0; cpu_strobe_i = 1'b0;
        pia1_cs_i = 1'b0; pia1_rs_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_ack", {7'd0, wb_ack_o}, 8'h00);
        check("reset_wb_data", wb_data_o, 8'hFF);
        check("reset_port_b", cpu_data_o, 8'hFF);
        check("idle_oe", {7'd0, cpu_data_oe}, 8'h00);
        for (int i = 0; i < 10; i++) wb_rd(i, 8'hFF);
        wb_rd(20, 8'h00);

        // Every row written, selected and scanned.
        for (int r = 0; r < 10; r++) begin
            wb_wr(r, 8'h50 | 8'(r), 1'b1);
            cpu_sel(8'(r));
            pia1_cs_i = 1'b1; cpu_we_i = 1'b0; pia1_rs_i = PIA_PORTB; #1;
            check("port_b_oe", {7'd0, cpu_data_oe}, 8'h01);
            pia1_cs_i = 1'b0;
            cpu_rd(8'h50 | 8'(r));
        end
        for (int r = 0; r < 10; r++) wb_rd(r, 8'h50 | 8'(r));
        wb_wr(1, 8'h00, 1'b0);
        wb_rd(1, 8'h51);

        // Auto-release after two scans.
        wb_wr(3, 8'hFE, 1'b1);
        wb_wr(13, 8'h02, 1'b1);
        wb_rd(13, 8'h02);
        cpu_sel(8'h03);
        cpu_rd(8'hFE); cpu_rd(8'hFE); cpu_rd(8'hFF);
        wb_rd(13, 8'h00);
        wb_rd(3, 8'hFF);

        // Scan counter: count, clear, wrap.
        wb_wr(20, 8'h00, 1'b1);
        cpu_sel(8'h00);
        repeat (20) cpu_rd(8'h50);
        wb_rd(20, 8'd20);
        wb_wr(20, 8'h55, 1'b1);
        wb_rd(20, 8'h00);
        repeat (255) cpu_rd(8'h50);
        wb_rd(20, 8'hFF);
        cpu_rd(8'h50);
        wb_rd(20, 8'h00);

        // Row select beyond the matrix and unmapped Wishbone address.
        cpu_sel(8'h0C);
        cpu_rd(8'hFF);
        wb_rd(20, 8'h00);
        wb_rd(25, 8'hFF);
        wb_wr(25, 8'h00, 1'b1);
        wb_rd(25, 8'hFF);
        wb_rd(0, 8'h50);

        // Row write collides with the expiring read of the same row.
        wb_wr(3, 8'hFE, 1'b1);
        wb_wr(13, 8'h01, 1'b1);
        cpu_sel(8'h03);
        fork
            wb_wr(3, 8'h7F, 1'b1);
            cpu_rd(8'hFE);
        join
        wb_rd(3, 8'h7F);
        wb_rd(13, 8'h01);
        cpu_rd(8'h7F);
        cpu_rd(8'hFF);
        wb_rd(13, 8'h00);

        // Scan clear collides with an increment.
        cpu_sel(8'h00);
        cpu_rd(8'h50); cpu_rd(8'h50);
        wb_rd(20, 8'h02);
        fork
            wb_wr(20, 8'h00, 1'b1);
            cpu_rd(8'h50);
        join
        wb_rd(20, 8'h00);

        // Reset arriving with a request in flight.
        wb_addr_i = 5'd2; wb_we_i = 1'b0; wb_sel_i = 1'b1;
        wb_cycle_i = 1'b1; wb_strobe_i = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        wb_cycle_i = 1'b0; wb_strobe_i = 1'b0;
        check("no_ack_in_reset", {7'd0, wb_ack_o}, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) wb_rd(i, 8'hFF);
        wb_rd(20, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        check("wb_queue_drained", 8'(wb_q.size()), 8'h00);
        check("cpu_queue_drained", 8'(cpu_q.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
